// File: rtl/mul_seq.sv
// Sequential multiplier: accumulates operand A once per tick of an external
// down-counter that is loaded with operand B.
module mul_seq #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] bus,
   input  logic         eqz,
   output logic         ldb,
   output logic         decb,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] prod,
   output logic         ovf
);

   typedef enum logic [1:0] {StIdle, StLoadB, StRun, StDone} state_e;

   state_e       state_q, state_d;
   logic [W-1:0] a_q, a_d;
   logic [W-1:0] prod_q, prod_d;
   logic         ovf_q, ovf_d;
   logic [W:0]   sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         prod_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         prod_q  <= prod_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      prod_d  = prod_q;
      ovf_d   = ovf_q;
      ldb     = 1'b0;
      decb    = 1'b0;
      done    = 1'b0;
      busy    = (state_q != StIdle);
      sum     = {1'b0, prod_q} + {1'b0, a_q};
      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_d     = bus;
               prod_d  = '0;
               ovf_d   = 1'b0;
               state_d = StLoadB;
            end
         end
         StLoadB: begin
            ldb     = 1'b1;
            state_d = StRun;
         end
         StRun: begin
            // A zero multiplicand finishes at once regardless of the count.
            if (!eqz && (a_q != '0)) begin
               decb   = 1'b1;
               prod_d = sum[W-1:0];
               ovf_d  = ovf_q | sum[W];
            end else begin
               state_d = StDone;
            end
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign prod = prod_q;
   assign ovf  = ovf_q;

endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 Parameter: W, 32, data width of bus, operand A and product.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request a multiply; sampled only in IDLE.
REQ-005 Port: bus  input  W  operand bus: A in the start cycle, B in the following cycle.
REQ-006 Port: eqz  input  1  from the external down-counter; high when its count equals 0.
REQ-007 Port: ldb  output  1  load strobe to the down-counter; the counter captures bus on the same edge.
REQ-008 Port: decb  output  1  decrement strobe to the down-counter.
REQ-009 Port: busy  output  1  high in every state except IDLE.
REQ-010 Port: done  output  1  one-cycle completion pulse.
REQ-011 Port: prod  output  W  product, held stable from done until the next accepted start.
REQ-012 Port: ovf  output  1  sticky flag; set when any accumulation carries out of bit W-1.

Function
REQ-013 The block SHALL compute A*B by repeated addition, using the external counter (ldb/decb/eqz) as the iteration count.
REQ-014 The block SHALL implement exactly four states: IDLE, LOADB, RUN, DONE.
REQ-015 IDLE: when start=1 at an edge, the block SHALL capture a_reg<=bus, set prod<=0 and ovf<=0, and move to LOADB; when start=0 it SHALL remain in IDLE.
REQ-016 LOADB: ldb SHALL be 1 for exactly this one cycle, and the state SHALL move to RUN unconditionally.
REQ-017 RUN with eqz=0 and a_reg!=0: decb SHALL be 1, prod<=prod+a_reg (mod 2^W), and ovf<=ovf|carry_out; the state SHALL stay in RUN.
REQ-018 RUN with eqz=1 or a_reg==0: decb SHALL be 0, prod SHALL be unchanged, and the state SHALL move to DONE.
REQ-019 DONE: done SHALL be 1 for exactly one cycle, then the state SHALL move to IDLE; start SHALL be ignored in DONE.
REQ-020 ldb SHALL be a Moore output of LOADB; decb SHALL be Mealy (RUN & ~eqz & a_reg!=0); ldb and decb SHALL never be high together.
REQ-021 With start sampled in cycle 0, done SHALL be high in cycle B+3 for a_reg!=0, and in cycle 3 for a_reg==0 or B==0.
REQ-022 start SHALL be ignored while busy=1; no state, operand or output SHALL change because of it.
REQ-023 prod SHALL wrap modulo 2^W; ovf SHALL remain set until the next accepted start.
REQ-024 No combinational path SHALL exist from start or bus to any output.

Reset
REQ-025 While rst_n=0: state=IDLE; ldb, decb, busy, done, ovf = 0; prod = 0; a_reg = 0; these SHALL take effect immediately, independent of clk.
REQ-026 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start accepted after release SHALL begin a clean operation.

Verification
REQ-027 A=5, B=3 -> ldb in cycle 1; decb in cycles 2-4; done in cycle 6; prod=15; ovf=0.
REQ-028 A=7, B=0 -> decb never asserted; done in cycle 3; prod=0.
REQ-029 A=0, B=1000 -> no decb; done in cycle 3; prod=0 (zero shortcut).
REQ-030 A=0x8000_0000, B=3 (W=32) -> prod=0x8000_0000; ovf=1; done in cycle 6.
REQ-031 start pulsed again in cycles 2 and 6 of an A=2, B=4 run -> ignored; single done in cycle 7; prod=8.
REQ-032 rst_n low in cycle 3 of an A=9, B=5 run -> busy=0 and prod=0 immediately, no done; a new run with A=1, B=1 -> prod=1.
